// File: rtl/nfifo_rr_reader.sv
// nfifo_rr_reader: round-robin reader for a multi-flow NFIFO.
// Picks one non-empty flow per cycle, tracks reads in flight for LATENCY
// cycles and collects the returned words into a 4-entry
// first-word-fall-through buffer that drives the TX handshake.
// Optional word counter: define NFIFO_RR_READER_STATS_EN to add STAT_WORDS.
module nfifo_rr_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int FLOWS      = 8,
    parameter int LATENCY    = 2
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [FLOWS-1:0]           FIFO_EMPTY,
    output logic [$clog2(FLOWS)-1:0]   FIFO_BLOCK_ADDR,
    output logic                       FIFO_READ,
    input  logic [DATA_WIDTH-1:0]      FIFO_DATA_OUT,
    input  logic                       FIFO_DATA_VLD,
    output logic [DATA_WIDTH-1:0]      TX_DATA,
    output logic [$clog2(FLOWS)-1:0]   TX_FLOW,
    output logic                       TX_SRC_RDY,
    input  logic                       TX_DST_RDY
`ifdef NFIFO_RR_READER_STATS_EN
    ,
    output logic [31:0]                STAT_WORDS
`endif
);

    localparam int FLOW_W    = $clog2(FLOWS);
    localparam int BUF_DEPTH = 4;

    // Arbiter state
    logic [FLOW_W-1:0] last_q;
    logic [FLOW_W-1:0] addr_q;

    // In-flight reads, stage 0 is the newest, stage LATENCY-1 meets FIFO_DATA_VLD
    logic [LATENCY-1:0]             infl_vld_q;
    logic [LATENCY-1:0][FLOW_W-1:0] infl_flow_q;

    // Output buffer
    logic [DATA_WIDTH-1:0] buf_data [BUF_DEPTH];
    logic [FLOW_W-1:0]     buf_flow [BUF_DEPTH];
    logic [1:0]            wr_ptr_q;
    logic [1:0]            rd_ptr_q;
    logic [2:0]            count_q;

    logic [FLOWS-1:0]  busy_mask;
    logic [2:0]        infl_cnt;
    logic              grant_found;
    logic [FLOW_W-1:0] grant_flow;
    logic [FLOW_W-1:0] cand;
    logic [2:0]        free_slots;
    logic              issue;
    logic              wr_en;
    logic              rd_en;

    // Flows with a read already in flight, and how many reads are outstanding
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        busy_mask = '0;
        infl_cnt  = '0;
        for (int s = 0; s < LATENCY; s++) begin
            if (infl_vld_q[s]) begin
                busy_mask[infl_flow_q[s]] = 1'b1;
                infl_cnt = infl_cnt + 3'd1;
            end
        end
    end

    // Round-robin search starting one past the last granted flow
    always_comb begin
        grant_found = 1'b0;
        grant_flow  = last_q;
        cand        = '0;
        for (int k = 1; k <= FLOWS; k++) begin
            cand = last_q + FLOW_W'(k);
            if (!grant_found && !FIFO_EMPTY[cand] && !busy_mask[cand]) begin
                grant_found = 1'b1;
                grant_flow  = cand;
            end
        end
    end

    // A read is only launched when its word is guaranteed a buffer slot
    assign free_slots = 3'd4 - count_q;
    assign issue      = !RESET && grant_found && (free_slots > infl_cnt);
    assign wr_en      = infl_vld_q[LATENCY-1] && FIFO_DATA_VLD;
    assign rd_en      = TX_SRC_RDY && TX_DST_RDY;

    assign FIFO_READ       = issue;
    assign FIFO_BLOCK_ADDR = RESET ? '0 : (issue ? grant_flow : addr_q);
    assign TX_SRC_RDY      = !RESET && (count_q != 3'd0);
    assign TX_DATA         = TX_SRC_RDY ? buf_data[rd_ptr_q] : '0;
    assign TX_FLOW         = TX_SRC_RDY ? buf_flow[rd_ptr_q] : '0;

    // Last-granted pointer and held block address move only on a read
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (RESET) begin
            last_q <= FLOW_W'(FLOWS - 1);
            addr_q <= '0;
        end else if (issue) begin
            last_q <= grant_flow;
            addr_q <= grant_flow;
        end
    end

    // Shift register of outstanding reads
    always_ff @(posedge CLK) begin
        if (RESET) begin
            infl_vld_q  <= '0;
            infl_flow_q <= '0;
        end else begin
            infl_vld_q[0]  <= issue;
            infl_flow_q[0] <= grant_flow;
            for (int s = 1; s < LATENCY; s++) begin
                infl_vld_q[s]  <= infl_vld_q[s-1];
                infl_flow_q[s] <= infl_flow_q[s-1];
            end
        end
    end

    // Buffer storage, written when the oldest in-flight read returns data
    always_ff @(posedge CLK) begin
        // NOTE: storage is not reset; occupancy and pointers alone decide which entries are meaningful.
        if (wr_en) begin
            buf_data[wr_ptr_q] <= FIFO_DATA_OUT;
            buf_flow[wr_ptr_q] <= infl_flow_q[LATENCY-1];
        end
    end

    // Buffer pointers and occupancy; write and transfer may coincide
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + {2'b00, wr_en} - {2'b00, rd_en};
        end
    end

`ifdef NFIFO_RR_READER_STATS_EN
    logic [31:0] stat_q;

    // Count transferred words, wrapping naturally at 2^32
    always_ff @(posedge CLK) begin
        if (RESET) stat_q <= '0;
        else if (rd_en) stat_q <= stat_q + 32'd1;
    end

    assign STAT_WORDS = stat_q;
`endif

endmodule

// File: tb/tb_nfifo_rr_reader.sv
// Testbench for nfifo_rr_reader (DATA_WIDTH=16, FLOWS=8, LATENCY=2).
// A queue-based reference model predicts reads, buffer contents and TX words.
module tb_nfifo_rr_reader;

    localparam int DW  = 16;
    localparam int FL  = 8;
    localparam int LAT = 2;
    localparam int FW  = 3;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [FL-1:0] FIFO_EMPTY = '1;
    logic [FW-1:0] FIFO_BLOCK_ADDR;
    logic          FIFO_READ;
    logic [DW-1:0] FIFO_DATA_OUT = '0;
    logic          FIFO_DATA_VLD = 1'b0;
    logic [DW-1:0] TX_DATA;
    logic [FW-1:0] TX_FLOW;
    logic          TX_SRC_RDY;
    logic          TX_DST_RDY = 1'b0;
`ifdef NFIFO_RR_READER_STATS_EN
    logic [31:0]   STAT_WORDS;
`endif

    nfifo_rr_reader #(.DATA_WIDTH(DW), .FLOWS(FL), .LATENCY(LAT)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_BLOCK_ADDR(FIFO_BLOCK_ADDR),
        .FIFO_READ(FIFO_READ),
        .FIFO_DATA_OUT(FIFO_DATA_OUT),
        .FIFO_DATA_VLD(FIFO_DATA_VLD),
        .TX_DATA(TX_DATA),
        .TX_FLOW(TX_FLOW),
        .TX_SRC_RDY(TX_SRC_RDY),
        .TX_DST_RDY(TX_DST_RDY)
`ifdef NFIFO_RR_READER_STATS_EN
        ,
        .STAT_WORDS(STAT_WORDS)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int            cyc;
        logic [FW-1:0] flow;
        logic [DW-1:0] data;
        bit            drop;
    } rd_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [FW-1:0] flow;
    } word_t;

    rd_t   pend[$];   // reads the model considers in flight
    rd_t   ghost[$];  // reads discarded by reset; the NFIFO still answers them
    word_t exp_q[$];  // words expected in the output buffer, oldest first

    int            cyc = 0;
    logic [FW-1:0] last_g;
    logic [FW-1:0] last_a;
    logic [FL-1:0] empty_v = '0;
    bit            dst_v = 1'b1;
    bit            spur_v = 1'b0;
    int            drop_pct = 0;
    int            drop_once = -1;
    int unsigned   stat_exp = 0;

    bit            obs_read;
    logic [FW-1:0] obs_addr;
    bit            obs_src;
    bit            obs_xfer;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model
    task automatic step(input bit rst);
        rd_t           r;
        bit            found;
        bit            busy;
        bit            exp_read;
        logic [FW-1:0] exp_f;
        logic [FW-1:0] f;
        int            n;
        @(negedge CLK);
        RESET         = rst;
        FIFO_EMPTY    = empty_v;
        TX_DST_RDY    = dst_v;
        FIFO_DATA_VLD = 1'b0;
        FIFO_DATA_OUT = DW'($urandom);
        if (ghost.size() > 0 && ghost[0].cyc == cyc - LAT) begin
            FIFO_DATA_VLD = !ghost[0].drop;
            FIFO_DATA_OUT = ghost[0].data;
        end else if (pend.size() > 0 && pend[0].cyc == cyc - LAT) begin
            FIFO_DATA_VLD = !pend[0].drop;
            FIFO_DATA_OUT = pend[0].data;
        end else if (spur_v && $urandom_range(0, 3) == 0) begin
            FIFO_DATA_VLD = 1'b1;
        end
        while (ghost.size() > 0 && ghost[0].cyc <= cyc - LAT) void'(ghost.pop_front());
        #1;
        obs_read = FIFO_READ;
        obs_addr = FIFO_BLOCK_ADDR;
        obs_src  = TX_SRC_RDY;
        obs_xfer = TX_SRC_RDY && dst_v;
        if (rst) begin
            check("rst_read", 32'(FIFO_READ), 32'(0));
            check("rst_src_rdy", 32'(TX_SRC_RDY), 32'(0));
            check("rst_tx_data", 32'(TX_DATA), 32'(0));
            check("rst_tx_flow", 32'(TX_FLOW), 32'(0));
            check("rst_addr", 32'(FIFO_BLOCK_ADDR), 32'(0));
            foreach (pend[i]) ghost.push_back(pend[i]);
            pend.delete();
            exp_q.delete();
            last_g   = FW'(FL - 1);
            last_a   = '0;
            stat_exp = 0;
        end else begin
            n     = pend.size();
            found = 1'b0;
            exp_f = last_a;
            for (int k = 1; k <= FL; k++) begin
                f    = FW'((int'(last_g) + k) % FL);
                busy = 1'b0;
                foreach (pend[i]) if (pend[i].flow == f) busy = 1'b1;
                if (!found && !empty_v[f] && !busy) begin
                    found = 1'b1;
                    exp_f = f;
                end
            end
            exp_read = found && ((4 - exp_q.size()) > n);
            if (!exp_read) exp_f = last_a;
            check("read", 32'(FIFO_READ), 32'(exp_read));
            check("addr", 32'(FIFO_BLOCK_ADDR), 32'(exp_f));
            check("src_rdy", 32'(TX_SRC_RDY), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                check("tx_data", 32'(TX_DATA), 32'(exp_q[0].data));
                check("tx_flow", 32'(TX_FLOW), 32'(exp_q[0].flow));
            end
`ifdef NFIFO_RR_READER_STATS_EN
            check("stat_words", STAT_WORDS, stat_exp);
`endif
            if (exp_q.size() > 0 && dst_v) begin
                void'(exp_q.pop_front());
                stat_exp++;
            end
            if (pend.size() > 0 && pend[0].cyc == cyc - LAT) begin
                r = pend.pop_front();
                if (!r.drop) exp_q.push_back('{data: r.data, flow: r.flow});
            end
            if (exp_read) begin
                r.cyc  = cyc;
                r.flow = exp_f;
                r.data = DW'($urandom);
                r.drop = (int'(exp_f) == drop_once) || ($urandom_range(0, 99) < drop_pct);
                if (int'(exp_f) == drop_once) drop_once = -1;
                pend.push_back(r);
                last_g = exp_f;
                last_a = exp_f;
            end
        end
        cyc++;
    endtask

    initial begin
        int lat;
        int xf;
        int cnt;
        int last_rd;
        int min_gap;

        // Reset held for 10 cycles with every flow non-empty
        empty_v = '0;
        dst_v   = 1'b1;
        repeat (10) step(1'b1);

        // First read goes to flow 0; its word appears LAT+1 cycles later
        step(1'b0);
        check("first_read", 32'(obs_read), 32'(1));
        check("first_addr", 32'(obs_addr), 32'(0));
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            lat++;
            if (obs_src) break;
        end
        check("first_latency", 32'(lat), 32'(LAT + 1));

        // Fairness with all flows full: one word per cycle
        repeat (4) step(1'b0);
        xf = 0;
        repeat (16) begin
            step(1'b0);
            xf += int'(obs_xfer);
        end
        check("throughput", 32'(xf), 32'(16));

        // Sparse flows 0, 3, 6
        empty_v = 8'hB6;
        cnt = 0;
        repeat (30) begin
            step(1'b0);
            if (obs_read && empty_v[obs_addr]) cnt++;
        end
        check("sparse_empty_addr", 32'(cnt), 32'(0));

        // Backpressure: credits run out, nothing is lost
        empty_v = '0;
        dst_v   = 1'b0;
        repeat (10) step(1'b0);
        cnt = 0;
        repeat (10) begin
            step(1'b0);
            cnt += int'(obs_read);
        end
        check("bp_no_read", 32'(cnt), 32'(0));
        check("bp_src_rdy", 32'(obs_src), 32'(1));
        dst_v = 1'b1;
        xf = 0;
        repeat (4) begin
            step(1'b0);
            xf += int'(obs_xfer);
        end
        check("bp_drain", 32'(xf), 32'(4));

        // Dropped read on flow 5, which must be read again afterwards
        empty_v   = ~8'h20;
        drop_once = 5;
        cnt = 0;
        repeat (12) begin
            step(1'b0);
            if (obs_read) cnt++;
        end
        check("drop_reread", 32'(cnt >= 2), 32'(1));

        // Single flow 2: in-flight mask spaces the reads
        empty_v = ~8'h04;
        last_rd = -100;
        min_gap = 100;
        repeat (20) begin
            step(1'b0);
            if (obs_read) begin
                if (cyc - 1 - last_rd < min_gap) min_gap = cyc - 1 - last_rd;
                last_rd = cyc - 1;
            end
        end
        check("flow2_gap", 32'(min_gap >= 2), 32'(1));

        // Reset mid-operation: late data is ignored, no word before a new read completes
        empty_v = '0;
        repeat (6) step(1'b0);
        step(1'b1);
        repeat (3) begin
            step(1'b0);
            check("post_reset_quiet", 32'(obs_src), 32'(0));
        end

        // Randomised traffic with drops, spurious valids and rare resets
        spur_v   = 1'b1;
        drop_pct = 10;
        repeat (800) begin
            empty_v = FL'($urandom);
            dst_v   = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 199) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nfifo_rr_reader.md
NFIFO_RR_READER -- requirements
Module: nfifo_rr_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of the data word.
REQ-002 SHALL have parameter FLOWS, default 8: number of NFIFO flows; power of two, 2..32.
REQ-003 SHALL have parameter LATENCY, default 2: cycles from FIFO_READ to FIFO_DATA_VLD; legal values 1 (OUTPUT_REG=0) or 2 (OUTPUT_REG=1).
REQ-004 SHALL have ports, in this order:
- CLK  in  1  sole clock, rising edge.
- RESET  in  1  synchronous, active-high.
- FIFO_EMPTY  in  FLOWS  per-flow empty flags from the NFIFO.
- FIFO_BLOCK_ADDR  out  log2(FLOWS)  flow selected for the read.
- FIFO_READ  out  1  read strobe for FIFO_BLOCK_ADDR.
- FIFO_DATA_OUT  in  DATA_WIDTH  read data from the NFIFO.
- FIFO_DATA_VLD  in  1  FIFO_DATA_OUT valid.
- TX_DATA  out  DATA_WIDTH  output word.
- TX_FLOW  out  log2(FLOWS)  flow the output word came from.
- TX_SRC_RDY  out  1  output word valid.
- TX_DST_RDY  in  1  consumer accepts the word.
REQ-005 Clocking and reset SHALL be one clock (CLK) with a synchronous, active-high reset (RESET).

Function
REQ-006 Arbitration SHALL be round-robin, at most one FIFO_READ per cycle.
- Search starts at (last granted flow + 1) mod FLOWS.
- Candidate flow: FIFO_EMPTY bit = 0 and no read to that flow in flight.
REQ-007 A read SHALL be issued only when output-buffer free slots exceed the number of reads in flight. The output buffer holds 4 entries; each entry is {data, flow}.
REQ-008 In-flight reads SHALL be tracked in a LATENCY-deep shift register of {valid, flow}.
- When the tail valid bit = 1 and FIFO_DATA_VLD = 1, {FIFO_DATA_OUT, flow} SHALL be written into the buffer.
- When the tail valid bit = 1 and FIFO_DATA_VLD = 0, the slot SHALL be dropped silently.
REQ-009 FIFO_DATA_VLD = 1 with no read in flight SHALL be ignored.
REQ-010 The output buffer SHALL be first-word-fall-through.
- TX_SRC_RDY = 1 whenever the buffer is non-empty.
- A word is transferred when TX_SRC_RDY = 1 and TX_DST_RDY = 1.
REQ-011 Buffer write and transfer in the same cycle SHALL both take effect, including when the buffer is full or has one entry. Occupancy changes by write minus transfer.
REQ-012 Buffer pointers SHALL be 2-bit and wrap modulo 4. Occupancy SHALL be a 3-bit count in the range 0..4.
REQ-013 With the buffer empty, no backpressure and LATENCY = L, TX_SRC_RDY SHALL rise L+1 cycles after the FIFO_READ cycle.
REQ-014 With TX_DST_RDY held at 1 and all flows non-empty, the block SHALL sustain one word per cycle.
REQ-015 The last-granted pointer SHALL advance only on a cycle with FIFO_READ = 1.
REQ-016 FIFO_BLOCK_ADDR SHALL hold its last value when FIFO_READ = 0.

Reset
REQ-017 While RESET = 1:
- FIFO_READ = 0, TX_SRC_RDY = 0, TX_DATA = 0, TX_FLOW = 0, FIFO_BLOCK_ADDR = 0.
- Buffer emptied; in-flight register cleared; last-granted pointer = FLOWS-1, so flow 0 is tried first.
REQ-018 On reset mid-operation:
- In-flight reads SHALL be discarded, and FIFO_DATA_VLD arriving in the cycles after reset SHALL be ignored.
- No output word SHALL appear before a new read completes.

Configuration
REQ-019 Macro NFIFO_RR_READER_STATS_EN defined: the block SHALL add output port STAT_WORDS (32 bits).
- Counts transferred TX words.
- Wraps modulo 2^32.
- Cleared by RESET.
REQ-020 Macro NFIFO_RR_READER_STATS_EN undefined: the port SHALL be absent and there SHALL be no counter logic. All other behaviour is identical.

Verification
REQ-021 Reset: hold RESET = 1 for 10 cycles with FIFO_EMPTY = 0x00 -> FIFO_READ = 0 and TX_SRC_RDY = 0 throughout; first read after release has FIFO_BLOCK_ADDR = 0.
REQ-022 Fairness: FIFO_EMPTY = 0x00 constant, TX_DST_RDY = 1, LATENCY = 2 -> FIFO_BLOCK_ADDR sequence 0,1,...,7,0; TX_FLOW sequence identical, delayed 3 cycles; one word per cycle.
REQ-023 Sparse flows: FIFO_EMPTY = 0xB6, only flows 0, 3 and 6 non-empty -> reads cycle 0,3,6,0; empty flows are never addressed.
REQ-024 Backpressure: TX_DST_RDY = 0 for 20 cycles -> at most 4 words buffered, zero reads once credits are exhausted, no word lost; on release, 4 words drain in order.
REQ-025 Drop and full-flow: FIFO_DATA_VLD = 0 on a read of flow 5 -> no TX word for that read, and flow 5 is eligible again. Single flow 2 non-empty with LATENCY = 2 -> flow 2 is read at most every 2nd cycle (in-flight mask).
REQ-026 Stats: with NFIFO_RR_READER_STATS_EN defined, 1000 transfers -> STAT_WORDS = 1000; preloaded to 0xFFFFFFFF, one more transfer -> STAT_WORDS = 0.
